// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: holds the CPU in reset, releases it, then waits for a stable result or a watchdog
module cpu_run_ctrl #(
    parameter int unsigned HOLD_CYCLES   = 5,
    parameter logic [31:0] PC_DEFAULT    = 32'h0,
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned WATCHDOG      = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] pc_start,
    input  logic        expect_valid,
    input  logic [31:0] expect_data,
    input  logic [31:0] cpu_result,
    output logic        cpu_rst_n,
    output logic [31:0] cpu_pc_init,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [31:0] cycles
);
    localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES - 1);
    localparam logic [31:0] STABLE_N  = 32'(STABLE_CYCLES);
    localparam logic [31:0] WDOG_N    = 32'(WATCHDOG);

    typedef enum logic [1:0] {IDLE, HOLD, RUN, DONE} state_t;

    state_t      state;
    logic [31:0] hold_cnt;
    logic [31:0] stab_cnt;
    logic [31:0] prev_res;
    logic [31:0] exp_q;
    logic        ev_q;
    logic        same;
    logic        finish;

    // cycles==0 marks the first RUN edge, which only primes prev_res
    assign same   = (cycles != 32'd0) && (cpu_result == prev_res);
    assign finish = same && (stab_cnt + 32'd1 == STABLE_N);

    // run sequencer: start latch, reset hold, stability/watchdog monitor, result report
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cpu_rst_n   <= 1'b0;
            cpu_pc_init <= PC_DEFAULT;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            cycles      <= 32'd0;
            hold_cnt    <= 32'd0;
            stab_cnt    <= 32'd0;
            prev_res    <= 32'd0;
            exp_q       <= 32'd0;
            ev_q        <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= HOLD;
                        cpu_rst_n   <= 1'b0;
                        cpu_pc_init <= pc_start;
                        exp_q       <= expect_data;
                        ev_q        <= expect_valid;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        timeout     <= 1'b0;
                        cycles      <= 32'd0;
                        hold_cnt    <= 32'd0;
                        stab_cnt    <= 32'd0;
                    end
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state     <= RUN;
                        cpu_rst_n <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 32'd1;
                    end
                end
                RUN: begin
                    cycles   <= cycles + 32'd1;
                    prev_res <= cpu_result;
                    stab_cnt <= same ? stab_cnt + 32'd1 : 32'd0;
                    if (finish) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b0;
                        pass    <= ev_q ? (cpu_result == exp_q) : 1'b1;
                    end else if (cycles + 32'd1 == WDOG_N) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                        pass    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: timeline model plus directed runs for cpu_run_ctrl
module tb_cpu_run_ctrl;
    localparam int H = 5;
    localparam int S = 16;
    localparam int W = 64;

    logic        clk = 0, clk_en = 0, rst = 0, start = 0, expect_valid = 0, chk_en = 0;
    logic [31:0] pc_start = 0, expect_data = 0, cpu_result = 0;
    logic        cpu_rst_n, busy, done, pass, timeout;
    logic [31:0] cpu_pc_init, cycles;
    int          n_chk = 0, n_fail = 0;

    cpu_run_ctrl #(.HOLD_CYCLES(H), .PC_DEFAULT(32'h0), .STABLE_CYCLES(S), .WATCHDOG(W)) dut (
        .clk(clk), .rst(rst), .start(start), .pc_start(pc_start),
        .expect_valid(expect_valid), .expect_data(expect_data), .cpu_result(cpu_result),
        .cpu_rst_n(cpu_rst_n), .cpu_pc_init(cpu_pc_init), .busy(busy), .done(done),
        .pass(pass), .timeout(timeout), .cycles(cycles)
    );

    always #5 if (clk_en) clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // model: e counts edges since the accepted start; RUN edge k happens at e = H + k
    bit          m_started = 0, m_fin = 0, m_pass = 0, m_tout = 0, m_ev = 0;
    int          m_e = 0, m_last = 0, m_fcyc = 0, m_k = 0;
    logic [31:0] m_pc = 0, m_exp = 0, m_prev = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_started = 0; m_fin = 0; m_pass = 0; m_tout = 0; m_pc = 0;
        end else if (start && (!m_started || m_fin)) begin
            m_started = 1; m_fin = 0; m_pass = 0; m_tout = 0; m_e = 0; m_last = 0;
            m_pc = pc_start; m_exp = expect_data; m_ev = expect_valid;
        end else if (m_started && !m_fin) begin
            m_e++;
            m_k = m_e - H;
            if (m_k >= 1) begin
                if (m_k == 1 || cpu_result !== m_prev) m_last = m_k;
                m_prev = cpu_result;
                if (m_k - m_last == S) begin
                    m_fin = 1; m_fcyc = m_k; m_tout = 0;
                    m_pass = m_ev ? (cpu_result == m_exp) : 1'b1;
                end else if (m_k == W) begin
                    m_fin = 1; m_fcyc = m_k; m_tout = 1; m_pass = 0;
                end
            end
        end
    end

    // compare DUT against the model every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, m_started && !m_fin);
            chk("done", done, m_fin);
            chk("pass", pass, m_fin && m_pass);
            chk("timeout", timeout, m_fin && m_tout);
            chk("cpu_rst_n", cpu_rst_n, m_fin || (m_started && m_e >= H));
            chk("cpu_pc_init", cpu_pc_init, m_pc);
            chk("cycles", cycles, m_fin ? m_fcyc : ((m_started && m_e > H) ? m_e - H : 0));
        end
    end

    function automatic logic [31:0] pat(input int mode, input int k);
        if (mode == 0) return (k <= 10) ? 32'(32'h100 + 3 * k) : 32'h37;
        if (mode == 1) return 32'(k & 1);
        return (k <= 47) ? 32'(32'h200 + k) : 32'h55;
    endfunction

    task automatic go(input logic [31:0] pc, input bit ev, input logic [31:0] ex);
        @(negedge clk);
        start = 1; pc_start = pc; expect_valid = ev; expect_data = ex;
        @(negedge clk);
        start = 0; pc_start = 32'hffff_ffff; expect_data = 32'hffff_ffff;
    endtask

    // called on the negedge right after the start edge; returns once done is seen
    task automatic run(input int mode, input int inj, output int low);
        low = 0;
        for (int m = 0; m < 300; m++) begin
            if (done) begin
                start = 0;
                return;
            end
            if (!cpu_rst_n) low++;
            cpu_result = pat(mode, m - H + 1);
            start = (m == inj);
            if (m == inj) begin
                pc_start = 32'h99; expect_data = 32'h0;
            end
            @(negedge clk);
        end
        n_chk++; n_fail++;
        $display("FAIL run_bound: done never rose within 300 cycles");
    endtask

    int low;

    initial begin
        #1 rst = 1;
        #2;
        chk("rst_cpu_rst_n", cpu_rst_n, 0);
        chk("rst_pc", cpu_pc_init, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cycles", cycles, 0);
        clk_en = 1;
        chk_en = 1;
        repeat (2) @(negedge clk);
        rst = 0;

        go(32'h40, 1, 32'h37);
        chk("t2_pc", cpu_pc_init, 32'h40);
        chk("t2_busy", busy, 1);
        run(0, -1, low);
        chk("t2_low_cycles", low, H);
        chk("t3_done", done, 1);
        chk("t3_pass", pass, 1);
        chk("t3_timeout", timeout, 0);
        chk("t3_cycles", cycles, 27);
        repeat (3) @(negedge clk);
        chk("t3_frozen", cycles, 27);
        chk("t3_cpu_run", cpu_rst_n, 1);

        go(32'h44, 1, 32'h36);
        chk("t6_restart_cycles", cycles, 0);
        chk("t6_restart_rst_n", cpu_rst_n, 0);
        run(0, -1, low);
        chk("t6_restart_low", low, H);
        chk("t4_pass_bad", pass, 0);
        chk("t4_timeout", timeout, 0);
        chk("t4_cycles", cycles, 27);

        go(32'h48, 0, 32'h36);
        run(0, -1, low);
        chk("t4_noexp_pass", pass, 1);

        go(32'h0, 1, 32'h1);
        run(1, -1, low);
        chk("t5_done", done, 1);
        chk("t5_timeout", timeout, 1);
        chk("t5_pass", pass, 0);
        chk("t5_cycles", cycles, W);

        go(32'h0, 1, 32'h55);
        run(2, -1, low);
        chk("t5_tie_timeout", timeout, 0);
        chk("t5_tie_pass", pass, 1);
        chk("t5_tie_cycles", cycles, W);

        go(32'h40, 1, 32'h37);
        run(0, H + 3, low);
        chk("t6_ign_pc", cpu_pc_init, 32'h40);
        chk("t6_ign_pass", pass, 1);
        chk("t6_ign_cycles", cycles, 27);

        go(32'h80, 1, 32'h37);
        for (int m = 0; m < H + 6; m++) begin
            cpu_result = pat(0, m - H + 1);
            @(negedge clk);
        end
        chk("t6_mid_run", cpu_rst_n, 1);
        #2 rst = 1;
        #1;
        chk("t6_abort_rst_n", cpu_rst_n, 0);
        chk("t6_abort_busy", busy, 0);
        chk("t6_abort_cycles", cycles, 0);
        @(negedge clk);
        rst = 0;
        repeat (2) @(negedge clk);
        chk("t6_idle_busy", busy, 0);
        go(32'h10, 1, 32'h37);
        run(0, -1, low);
        chk("t6_after_pc", cpu_pc_init, 32'h10);
        chk("t6_after_pass", pass, 1);
        chk("t6_after_cycles", cycles, 27);

        @(negedge clk);
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
